// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared encodings and event layout for the PS/2 key event controller
package ps2_pkg;

  // Framing FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Scancode prefixes folded into the following key event
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Event word width: {ext, brk, code}
  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // PS/2 uses odd parity over the data byte plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - synchronizers for ps2_clk/ps2_data and ps2_clk falling-edge detect
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;

  // Shift both raw lines through their synchronizer chains; idle lines are high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync[0]  <= ps2_clk;
      r_data_sync[0] <= ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_clk_sync[i]  <= r_clk_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  // Data and clock chains have equal depth, so data_s lines up with fall
  assign data_s = r_data_sync[SYNC_STAGES-1];
  assign fall   = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_event_controller.sv
// rtl/ps2_key_event_controller.sv - PS/2 framing, E0/F0 prefix folding and event FIFO
module ps2_key_event_controller
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] evt_data,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] led,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic             w_data_s;
  logic             w_fall;

  logic [1:0]       r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_ext_pend;
  logic             r_brk_pend;
  logic             r_frame_err;
  logic             r_push;
  logic [EVT_W-1:0] r_push_evt;

  ps2_evt_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_led;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  ps2_evt_t         w_push_evt;
  ps2_evt_t         w_head;

  ps2_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (w_data_s),
    .fall     (w_fall)
  );

  // Frame the 11-bit packet, watch for stalls and fold prefixes into one event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_frame_err <= 1'b0;
      r_push      <= 1'b0;
      r_push_evt  <= '0;
    end else begin
      r_frame_err <= 1'b0;
      r_push      <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
        if (w_fall) begin
          if (!w_data_s) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end else begin
            r_frame_err <= 1'b1;
          end
        end
      end else if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          ST_DATA: begin
            r_shift <= {w_data_s, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            r_parity <= w_data_s;
            r_state  <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            if (w_data_s && odd_parity_ok(r_shift, r_parity)) begin
              if (r_shift == PS2_EXT) begin
                r_ext_pend <= 1'b1;
              end else if (r_shift == PS2_BRK) begin
                r_brk_pend <= 1'b1;
              end else begin
                r_push     <= 1'b1;
                r_push_evt <= {r_ext_pend, r_brk_pend, r_shift};
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_brk_pend  <= 1'b0;
            end
          end
        endcase
      end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        // Keyboard stopped clocking mid-frame: abandon it and any pending prefix
        r_state     <= ST_IDLE;
        r_to_cnt    <= '0;
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_brk_pend  <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign evt_valid  = (r_count != '0);
  assign w_pop      = evt_valid & evt_ready;
  // A pop in the same cycle frees the slot the push needs
  assign w_push_ok  = r_push & (~w_full | w_pop);
  assign w_push_evt = ps2_evt_t'(r_push_evt);
  assign w_head     = r_mem[r_rd_ptr];

  // Event FIFO storage, pointers, occupancy, debug LED and overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_led      <= 8'h01;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_push & w_full & ~w_pop;
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_evt;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        if (!w_push_evt.brk) begin
          r_led <= w_push_evt.code;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign evt_data  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_break = w_head.brk;
  assign led       = r_led;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_controller.sv
// tb/tb_ps2_key_event_controller.sv - randomized self-checking bench with event-level model
module tb_ps2_key_event_controller;

  localparam int DEPTH = 4;
  localparam int TO    = 300;
  localparam int SS    = 2;
  localparam int H     = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_data;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic [7:0] led;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_key_event_controller #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .evt_data  (evt_data),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .led       (led),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending events in FIFO order, prefix state, LED and pulse counts
  logic [9:0] exp_q[$];
  bit         m_ext = 0;
  bit         m_brk = 0;
  logic [7:0] m_led = 8'h01;
  int         m_err = 0;
  int         m_ovf = 0;
  int         err_seen = 0;
  int         ovf_seen = 0;
  bit         rr_en = 0;

  task automatic model_frame(input logic [7:0] b, input bit good, input bit pop_same_cycle);
    if (!good) begin
      m_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (exp_q.size() < DEPTH || pop_same_cycle) begin
        exp_q.push_back({m_ext, m_brk, b});
        if (!m_brk) m_led = b;
      end else begin
        m_ovf++;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Consumer side: count pulses, check popped events and head stability under stall
  logic [9:0] prev_head;
  bit         prev_stall = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (frame_err) err_seen++;
      if (overflow) ovf_seen++;
      if (prev_stall) check("hold", {22'd0, evt_ext, evt_break, evt_data}, {22'd0, prev_head});
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("spurious_evt", {22'd0, evt_ext, evt_break, evt_data}, 32'hFFFF);
        else check("evt", {22'd0, evt_ext, evt_break, evt_data}, {22'd0, exp_q.pop_front()});
      end
      prev_stall = evt_valid && !evt_ready;
      prev_head  = {evt_ext, evt_break, evt_data};
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rr_en) evt_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // One PS/2 bit: data set while clock high, then a low and a high phase.
  // mode 1 pulses evt_ready onto the FIFO write cycle; mode 2 measures latency.
  task automatic ps2_bit(input logic v, input int mode);
    ps2_data = v;
    clk_wait(1);
    ps2_clk = 1'b0;
    if (mode == 2) begin
      int  k = 0;
      bit  seen = 0;
      for (int i = 1; i <= 10 && !seen; i++) begin
        @(posedge clk);
        #1;
        k = i;
        if (evt_valid) seen = 1;
      end
      check("latency", k, SS + 2);
    end else if (mode == 1) begin
      clk_wait(SS + 1);
      evt_ready = 1'b1;
      clk_wait(1);
      evt_ready = 1'b0;
    end
    clk_wait(H);
    ps2_clk = 1'b1;
    clk_wait(H);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int mode);
    model_frame(b, !(bad_par || bad_stop), mode == 1);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit((~^b) ^ bad_par, 0);
    ps2_bit(!bad_stop, mode);
    ps2_data = 1'b1;
    clk_wait(8);
  endtask

  task automatic bad_start();
    m_err++;
    ps2_bit(1'b1, 0);
    clk_wait(8);
  endtask

  task automatic after_frame();
    clk_wait(10);
    check("frame_err_cnt", err_seen, m_err);
    check("overflow_cnt", ovf_seen, m_ovf);
    check("led", {24'd0, led}, {24'd0, m_led});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         r;

    // Reset state
    clk_wait(5);
    check("rst_valid", {31'd0, evt_valid}, 0);
    check("rst_data", {24'd0, evt_data}, 0);
    check("rst_ext_brk", {30'd0, evt_ext, evt_break}, 0);
    check("rst_led", {24'd0, led}, 32'h01);
    check("rst_pulses", {30'd0, frame_err, overflow}, 0);
    rst_n = 1'b1;
    clk_wait(5);

    // Single make code, with pin-to-valid latency
    evt_ready = 1'b1;
    send_frame(8'h1C, 0, 0, 2);
    after_frame();

    // Break and extended break prefixes fold into single events
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    after_frame();
    check("led_after_breaks", {24'd0, led}, 32'h1C);

    // Parity error then good byte
    send_frame(8'h1C, 1, 0, 0);
    after_frame();
    send_frame(8'h32, 0, 0, 0);
    after_frame();

    // Timeout after 4 data bits, then recovery
    m_err++;
    m_ext = 0;
    m_brk = 0;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 0);
    ps2_data = 1'b1;
    clk_wait(TO + 50);
    after_frame();
    send_frame(8'h1C, 0, 0, 0);
    after_frame();

    // Fill the FIFO, overflow on the fifth, then push with a simultaneous pop
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
    after_frame();
    check("valid_when_full", {31'd0, evt_valid}, 1);
    send_frame(8'h06, 0, 0, 1);
    after_frame();
    send_frame(8'h07, 0, 0, 0);
    after_frame();
    evt_ready = 1'b1;
    clk_wait(10);
    check("drained_full", exp_q.size(), 0);

    // Reset mid-frame with two events queued
    evt_ready = 1'b0;
    send_frame(8'h2A, 0, 0, 0);
    send_frame(8'h2B, 0, 0, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, evt_valid}, 0);
    check("midrst_led", {24'd0, led}, 32'h01);
    exp_q.delete();
    m_ext = 0;
    m_brk = 0;
    m_led = 8'h01;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    clk_wait(4);
    rst_n = 1'b1;
    clk_wait(4);
    evt_ready = 1'b1;
    send_frame(8'h1C, 0, 0, 0);
    after_frame();

    // Random traffic with random consumer back-pressure
    rr_en = 1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      b = 8'($urandom_range(0, 255));
      if (r < 20) b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      r = int'($urandom_range(0, 99));
      if (r < 5 && !m_ext && !m_brk) bad_start();
      else send_frame(b, r >= 5 && r < 15, r >= 15 && r < 20, 0);
      after_frame();
    end
    rr_en = 0;
    evt_ready = 1'b1;
    clk_wait(20);
    check("drained_final", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
